// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter: round-robin arbiter sharing one 4-phase req/ack CDC handshake channel among NUM_REQ requesters
module cdc_hs_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       src_clk,
  input  logic                       src_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       xfer_req,
  output logic [WIDTH-1:0]           xfer_data,
  input  logic                       xfer_ack_sync,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       xfer_done,
  output logic                       timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  localparam logic [IW:0] N_EXT = (IW + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  state_t state;
  logic [IW-1:0] last_grant, win, idx;
  logic [IW:0] sum;
  logic [CW-1:0] cnt;
  logic found, accept, timed_out;
  always_comb begin
    win = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, last_grant} + (IW + 1)'(k + 1);
      idx = sum >= N_EXT ? IW'(sum - N_EXT) : IW'(sum);
      if (!found && req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign accept = state == IDLE && !xfer_ack_sync && !src_rst && found;
  assign req_ready = accept ? ONE << win : '0;
  always_ff @(posedge src_clk) begin
    xfer_done <= 1'b0;
    timeout_err <= 1'b0;
    if (src_rst) begin
      state <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      xfer_req <= 1'b0;
      busy <= 1'b0;
      xfer_data <= '0;
      grant_id <= '0;
      cnt <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= REQ;
          xfer_req <= 1'b1;
          busy <= 1'b1;
          xfer_data <= req_data[win*WIDTH +: WIDTH];
          grant_id <= win;
          last_grant <= win;
          cnt <= '0;
          timed_out <= 1'b0;
        end
        REQ: if (xfer_ack_sync) begin
          state <= RELEASE;
          xfer_req <= 1'b0;
        end else if (TIMEOUT_CYC > 0 && cnt == T_LAST) begin
          state <= RELEASE;
          xfer_req <= 1'b0;
          timeout_err <= 1'b1;
          timed_out <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RELEASE: if (!xfer_ack_sync) begin
          state <= IDLE;
          busy <= 1'b0;
          xfer_done <= !timed_out;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
